pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core with precise exceptions.
- Successor to the fixed per-stage registers; one module is instantiated between every stage pair (D/E/M/W).
- Carries a generic multi-channel payload, plus instr, pc, a valid bit and exception state.
- Supports hold, bubble-flush and exception-flush, and merges stage-local exceptions with upstream ones under first-exception-wins priority.

---
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register for the five-stage MIPS core.
//            Carries a multi-channel payload plus instr, pc, valid, branch
//            delay flag and exception state. Supports hold, bubble flush and
//            exception flush, and merges stage-local exceptions with upstream
//            ones (upstream wins).
//            Optional hold/bubble performance counters are enabled by the
//            macro PIPE_STAGE_PERF_CNT_EN; without it the counter ports are
//            tied to zero and no counter flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_CH     = 3,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     flush,
    input  logic                     we,
    input  logic                     valid_in,
    input  logic [31:0]              instr_in,
    input  logic [31:0]              pc_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     bd_in,
    input  logic [4:0]               ex_code_in,
    input  logic                     ex_local,
    input  logic [4:0]               ex_local_code,
    output logic                     valid_out,
    output logic [31:0]              instr_out,
    output logic [31:0]              pc_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     bd_out,
    output logic [4:0]               ex_code_out,
    output logic                     has_ex_out,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int c_PAYLOAD_W = NUM_CH * DATA_W;

    logic                   r_valid;
    logic [31:0]            r_instr;
    logic [31:0]            r_pc;
    logic [c_PAYLOAD_W-1:0] r_data;
    logic                   r_bd;
    logic [4:0]             r_ex_code;
    logic                   r_has_ex;

    logic [4:0]             w_merged_code;

    // First-exception-wins merge: an older (upstream) exception masks any
    // exception raised by the producing stage; bubbles never carry one.
    always_comb begin
        w_merged_code = 5'd0;
        if (valid_in) begin
            if (ex_code_in != 5'd0) begin
                w_merged_code = ex_code_in;
            end else if (ex_local) begin
                w_merged_code = ex_local_code;
            end
        end
    end

    // Stage register: reset > exception flush > bubble flush > advance/hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_instr   <= 32'd0;
            r_pc      <= 32'd0;
            r_data    <= '0;
            r_bd      <= 1'b0;
            r_ex_code <= 5'd0;
            r_has_ex  <= 1'b0;
        end else if (req) begin
            r_valid   <= 1'b0;
            r_instr   <= 32'd0;
            r_pc      <= HANDLER_PC;
            r_data    <= '0;
            r_bd      <= 1'b0;
            r_ex_code <= 5'd0;
            r_has_ex  <= 1'b0;
        end else if (flush) begin
            // Bubble keeps pc/bd of the displaced instruction so EPC stays
            // correct if an interrupt is taken on the bubble.
            r_valid   <= 1'b0;
            r_instr   <= 32'd0;
            r_pc      <= pc_in;
            r_data    <= '0;
            r_bd      <= bd_in;
            r_ex_code <= 5'd0;
            r_has_ex  <= 1'b0;
        end else if (we) begin
            r_valid   <= valid_in;
            r_instr   <= instr_in;
            r_pc      <= pc_in;
            r_data    <= data_in;
            r_bd      <= bd_in;
            r_ex_code <= w_merged_code;
            r_has_ex  <= valid_in & (w_merged_code != 5'd0);
        end
    end

    assign valid_out   = r_valid;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc;
    assign data_out    = r_data;
    assign bd_out      = r_bd;
    assign ex_code_out = r_ex_code;
    assign has_ex_out  = r_has_ex;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating hold/bubble counters; an exception flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!req) begin
            if (flush) begin
                if (r_flush_cnt != {CNT_W{1'b1}}) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end else if (!we) begin
                if (r_stall_cnt != {CNT_W{1'b1}}) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg. A reference model written
//            from the stage's rules predicts every registered output; the
//            driver queues predictions and an independent monitor compares
//            them against the DUT one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DATA_W     = 32;
    localparam int          NUM_CH     = 3;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam int          CNT_W      = 2;
    localparam int          PW         = NUM_CH * DATA_W;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          reset, req, flush, we, valid_in, bd_in, ex_local;
    logic [31:0]   instr_in, pc_in;
    logic [PW-1:0] data_in;
    logic [4:0]    ex_code_in, ex_local_code;
    logic          valid_out, bd_out, has_ex_out;
    logic [31:0]   instr_out, pc_out;
    logic [PW-1:0] data_out;
    logic [4:0]    ex_code_out;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .HANDLER_PC(HANDLER_PC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .we(we),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .data_in(data_in), .bd_in(bd_in), .ex_code_in(ex_code_in),
        .ex_local(ex_local), .ex_local_code(ex_local_code),
        .valid_out(valid_out), .instr_out(instr_out), .pc_out(pc_out),
        .data_out(data_out), .bd_out(bd_out), .ex_code_out(ex_code_out),
        .has_ex_out(has_ex_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [PW-1:0] data;
        logic          bd;
        logic [4:0]    code;
        logic          has_ex;
        int            stalls;
        int            bubbles;
    } exp_t;

    exp_t m;          // model state
    exp_t q[$];       // predictions awaiting the monitor
    int   checks = 0;
    int   errors = 0;
    bit   perf_en;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: next visible state from the current inputs.
    task automatic model_step();
        if (reset) begin
            m = '{valid:0, instr:0, pc:0, data:'0, bd:0, code:0, has_ex:0, stalls:0, bubbles:0};
        end else if (req) begin
            m.valid = 0; m.instr = 0; m.pc = HANDLER_PC; m.data = '0;
            m.bd = 0; m.code = 0; m.has_ex = 0;
        end else if (flush) begin
            m.valid = 0; m.instr = 0; m.pc = pc_in; m.data = '0;
            m.bd = bd_in; m.code = 0; m.has_ex = 0;
            if (perf_en && m.bubbles < CNT_MAX) m.bubbles = m.bubbles + 1;
        end else if (we) begin
            int code;
            code = 0;
            if (valid_in) begin
                if (ex_code_in != 0)    code = ex_code_in;
                else if (ex_local)      code = ex_local_code;
            end
            m.valid = valid_in; m.instr = instr_in; m.pc = pc_in; m.data = data_in;
            m.bd = bd_in; m.code = 5'(code); m.has_ex = (code != 0);
        end else begin
            if (perf_en && m.stalls < CNT_MAX) m.stalls = m.stalls + 1;
        end
    endtask

    // Predict, then let the DUT take the edge; inputs change at negedge.
    task automatic step();
        model_step();
        q.push_back(m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; req = 0; flush = 0; we = 0; valid_in = 0; bd_in = 0;
        ex_local = 0; instr_in = 0; pc_in = 0; data_in = '0;
        ex_code_in = 0; ex_local_code = 0;
    endtask

    task automatic rand_payload();
        instr_in = $urandom;
        pc_in    = $urandom & 32'hFFFF_FFFC;
        for (int k = 0; k < NUM_CH; k++) data_in[k*DATA_W +: DATA_W] = $urandom;
        bd_in    = 1'($urandom_range(0, 1));
    endtask

    // Monitor: the register presents a new state every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("valid_out",   128'(valid_out),   128'(e.valid));
                chk("instr_out",   128'(instr_out),   128'(e.instr));
                chk("pc_out",      128'(pc_out),      128'(e.pc));
                chk("data_out",    128'(data_out),    128'(e.data));
                chk("bd_out",      128'(bd_out),      128'(e.bd));
                chk("ex_code_out", 128'(ex_code_out), 128'(e.code));
                chk("has_ex_out",  128'(has_ex_out),  128'(e.has_ex));
                chk("stall_cnt",   128'(stall_cnt),   128'(e.stalls));
                chk("flush_cnt",   128'(flush_cnt),   128'(e.bubbles));
            end
        end
    end

    initial begin
`ifdef PIPE_STAGE_PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        m = '{valid:0, instr:0, pc:0, data:'0, bd:0, code:0, has_ex:0, stalls:0, bubbles:0};
        idle_inputs();
        reset = 1;
        step();
        step();

        // Basic load
        idle_inputs();
        we = 1; valid_in = 1; instr_in = 32'h2408_0005; pc_in = 32'h3000;
        data_in[DATA_W-1:0] = 32'h1234;
        step();

        // Hold three cycles with moving inputs
        we = 0;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            valid_in = 1'($urandom_range(0, 1));
            ex_local = 1; ex_local_code = 5'd9;
            step();
        end

        // Bubble while holding
        idle_inputs();
        flush = 1; pc_in = 32'h3008; bd_in = 1;
        step();

        // Exception flush beats bubble
        rand_payload();
        req = 1; flush = 1; we = 1; valid_in = 1;
        step();

        // Exception merge cases
        idle_inputs();
        rand_payload();
        we = 1; valid_in = 1; ex_code_in = 5'd4; ex_local = 1; ex_local_code = 5'd12;
        step();
        ex_code_in = 5'd0;
        step();
        valid_in = 0;
        step();
        valid_in = 1; ex_local_code = 5'd0;
        step();

        // Long hold saturates the stall counter, then reset mid-hold
        we = 0;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        step();
        reset = 0;

        // Several bubbles to saturate the bubble counter
        flush = 1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            step();
        end
        flush = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            req           = ($urandom_range(0, 19) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            we            = ($urandom_range(0, 9) < 7);
            valid_in      = ($urandom_range(0, 3) != 0);
            ex_code_in    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            ex_local      = 1'($urandom_range(0, 1));
            ex_local_code = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rand_payload();
            step();
        end

        idle_inputs();
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d required=0 pending", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
